// File: rtl/cpu_io_periph.sv
// CPU I/O port peripheral: LED/switch registers, 4-entry receive FIFO and
// reloadable down-counter timer behind an 8-port window with a level interrupt.
module cpu_io_periph #(
    parameter logic [7:0] BASE = 8'h00
) (
    input  logic       CLK,
    input  logic       xRESET_N,
    input  logic [7:0] PORTID,
    input  logic [7:0] OUTPORT,
    input  logic       WSTROBE,
    input  logic       WSTROBEK,
    input  logic       RSTROBE,
    output logic [7:0] INPORT,
    output logic       INT,
    input  logic [7:0] SW,
    output logic [7:0] LED,
    input  logic [7:0] RX_DATA,
    input  logic       RX_VALID,
    output logic       RX_READY
);
    localparam logic [2:0] OFF_LED    = 3'd0;
    localparam logic [2:0] OFF_SW     = 3'd1;
    localparam logic [2:0] OFF_FIFO   = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_IE     = 3'd4;
    localparam logic [2:0] OFF_RELOAD = 3'd5;
    localparam logic [2:0] OFF_TCOUNT = 3'd6;

    typedef struct packed {
        logic       wr;
        logic       rd;
        logic [2:0] off;
        logic [7:0] data;
    } io_req_t;

    io_req_t    req;
    logic       sel;
    logic [1:0] ie;
    logic [7:0] reload, tcount;
    logic       tflag, ovf;
    logic [7:0] sw_s1, sw_s2;
    logic [7:0] mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count;
    logic       nempty, full, push, pop;
    logic       wr_reload, wr_status, tflag_set, ovf_set;
    logic [7:0] rdata;

    // Constant-port writes bypass the BASE match and use the low offset bits only.
    assign sel = (PORTID[7:3] == BASE[7:3]);
    always_comb begin
        req.wr   = (WSTROBE & sel) | WSTROBEK;
        req.rd   = RSTROBE & sel;
        req.off  = PORTID[2:0];
        req.data = OUTPORT;
    end

    assign nempty   = (count != 3'd0);
    assign full     = (count == 3'd4);
    assign RX_READY = !full;
    assign push     = RX_VALID & RX_READY;
    assign pop      = req.rd & (req.off == OFF_FIFO) & nempty;
    assign ovf_set  = RX_VALID & full;

    assign wr_reload = req.wr & (req.off == OFF_RELOAD);
    assign wr_status = req.wr & (req.off == OFF_STATUS);
    assign tflag_set = !wr_reload & (reload != 8'd0) & (tcount == 8'd1);

    always_comb begin
        rdata = 8'h00;
        if (sel) begin
            case (req.off)
                OFF_LED:    rdata = LED;
                OFF_SW:     rdata = sw_s2;
                OFF_FIFO:   rdata = nempty ? mem[rd_ptr] : 8'h00;
                OFF_STATUS: rdata = {4'b0, ovf, tflag, full, nempty};
                OFF_IE:     rdata = {6'b0, ie};
                OFF_RELOAD: rdata = reload;
                OFF_TCOUNT: rdata = tcount;
                default:    rdata = 8'h00;
            endcase
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= RX_DATA;
    end

    always_ff @(posedge CLK or negedge xRESET_N) begin
        if (!xRESET_N) begin
            INPORT <= 8'h00;
            INT    <= 1'b0;
            LED    <= 8'h00;
            ie     <= 2'b00;
            reload <= 8'h00;
            tcount <= 8'h00;
            tflag  <= 1'b0;
            ovf    <= 1'b0;
            sw_s1  <= 8'h00;
            sw_s2  <= 8'h00;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            INPORT <= rdata;
            INT    <= (ie[0] & nempty) | (ie[1] & tflag);
            sw_s1  <= SW;
            sw_s2  <= sw_s1;

            if (req.wr && req.off == OFF_LED) LED <= req.data;
            if (req.wr && req.off == OFF_IE)  ie  <= req.data[1:0];

            if (wr_reload) begin
                reload <= req.data;
                tcount <= req.data;
            end else if (reload == 8'd0) begin
                tcount <= 8'd0;
            end else if (tcount <= 8'd1) begin
                tcount <= reload;
            end else begin
                tcount <= tcount - 8'd1;
            end

            // Setting a sticky flag wins over a same-cycle clear.
            if (tflag_set)                      tflag <= 1'b1;
            else if (wr_status && req.data[2])  tflag <= 1'b0;
            if (ovf_set)                        ovf   <= 1'b1;
            else if (wr_status && req.data[3])  ovf   <= 1'b0;

            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end
endmodule
